// File: rtl/apb_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
//   Shared types and constants for the APB master arbiter.
//   - state_t   : transfer FSM states (IDLE, SETUP, ACCESS)
//   - CNT_W     : width of the ACCESS-phase cycle counter
//   - req_idx_w : index width needed to address n requesters
// -----------------------------------------------------------------------------
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // ACCESS_CYCLES tops out at 15, so four bits always suffice.
  localparam int CNT_W = 4;

  // $clog2(1) is 0; keep at least one bit so index vectors stay legal.
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter_if
//   Bundles the requester handshake and the APB bus of the arbiter.
//   Requester side : req_valid/req_write/req_addr/req_wdata in,
//                    req_ready/rsp_valid/rsp_rdata out (one bit per requester,
//                    requester i in slice i of the packed field vectors).
//   APB side       : PSELx/PWRITE/PADDR/PWDATA out, PRDATA in.
//   modport master : the arbiter (APB master, serves the requesters).
//   modport slave  : everything around it (requesters plus APB slave).
// -----------------------------------------------------------------------------
interface apb_master_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_write;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_rdata;

  logic                        PSELx;
  logic                        PWRITE;
  logic [ADDR_WIDTH-1:0]       PADDR;
  logic [DATA_WIDTH-1:0]       PWDATA;
  logic [DATA_WIDTH-1:0]       PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, PSELx, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, PSELx, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
//   Purely combinational round-robin pick. Scans req upward starting at ptr,
//   wrapping at N_REQ, and reports the first set bit.
//   req   in  N_REQ  pending requests
//   ptr   in  IDX_W  highest-priority index (always < N_REQ)
//   grant out N_REQ  one-hot winner (0 when nothing pending)
//   idx   out IDX_W  winner index
//   any   out 1      at least one request pending
// -----------------------------------------------------------------------------
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = req_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               pos_i;
  logic [IDX_W-1:0] pos;

  // NOTE: every variable written in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos_i = 0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Wrap at N_REQ, not at 2**IDX_W, so unused indices are never visited.
      pos_i = int'(ptr) + k;
      if (pos_i >= N_REQ) pos_i = pos_i - N_REQ;
      pos = IDX_W'(pos_i);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//   Shares one APB bus between N_REQ requesters. In IDLE a round-robin winner
//   is accepted (req_ready pulse) and its fields are registered onto the bus;
//   SETUP lasts one cycle, ACCESS lasts ACCESS_CYCLES cycles (no PREADY), then
//   the winner gets a one-cycle rsp_valid pulse with the read data (0 for
//   writes). Accept-to-response latency is 2+ACCESS_CYCLES cycles.
//   PCLK    in  bus clock, rising edge
//   PRESETn in  asynchronous active-low reset
//   bus     master modport of apb_master_arbiter_if (handshake + APB)
// -----------------------------------------------------------------------------
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_master_arbiter_if.master bus
);

  localparam int              IDX_W    = req_idx_w(N_REQ);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        win_idx;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        owner_q;
  logic                    any_req;
  logic                    accept;
  logic                    acc_last;
  logic [CNT_W-1:0]        cnt_q;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  apb_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_req)
  );

  assign acc_last = (state_q == ACCESS) && (cnt_q == ACC_LAST);

  // Fields of the current winner; only sampled in the accepting cycle.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      // Gating with PRESETn keeps req_ready low while reset is asserted,
      // even though the FSM already sits in IDLE.
      IDLE: begin
        if (any_req && PRESETn) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (acc_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = accept ? grant : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every register here is a control or bus register, so all of them
  // are cleared by the async reset; an in-flight transfer is simply dropped.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      bus.PSELx     <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= '0;

      if (accept) begin
        ptr_q      <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
        owner_q    <= grant;
        bus.PSELx  <= 1'b1;
        bus.PWRITE <= sel_write;
        bus.PADDR  <= sel_addr;
        bus.PWDATA <= sel_wdata;
      end

      if (state_q == SETUP)                    cnt_q <= '0;
      else if (state_q == ACCESS && !acc_last) cnt_q <= cnt_q + 1'b1;

      // Last ACCESS edge: close the transfer; PADDR/PWDATA keep their value.
      if (acc_last) begin
        bus.PSELx     <= 1'b0;
        bus.rsp_valid <= owner_q;
        bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
      end
    end
  end

endmodule
